// File: rtl/tone_scheduler.sv
// Tone-code scheduler: live keyboard codes arbitrated against an autoplay song sequencer.
// Optional build macro TONE_SCHED_LOOP_EN makes the song repeat until stopped or preempted.
module tone_scheduler #(
  parameter  int BEAT_TICKS = 25_000_000,
  parameter  int GAP_TICKS  = 1_000_000,
  parameter  int SONG_DEPTH = 32,
  localparam int AW         = (SONG_DEPTH > 1) ? $clog2(SONG_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    key_code,
  input  logic          play_start,
  input  logic          play_stop,
  input  logic          song_we,
  input  logic [AW-1:0] song_waddr,
  input  logic [8:0]    song_wdata,
  output logic [4:0]    tone,
  output logic          busy,
  output logic [AW-1:0] note_idx,
  output logic          song_done,
  output logic [2:0]    dbg_state
);

  localparam int MAX_TICKS = (BEAT_TICKS > GAP_TICKS) ? BEAT_TICKS : GAP_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(SONG_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_NOTE = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    tone_q, tone_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    beats_q, beats_d;
  logic [3:0]    beat_q, beat_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          done_q, done_d;

  logic [8:0]    song_q [SONG_DEPTH];
  logic [8:0]    entry;
  logic [4:0]    entry_raw;
  logic [4:0]    entry_tone;
  logic [3:0]    entry_beats;
  logic          key_ok;
  logic          preempt;

  // Song table has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (song_we) begin
      song_q[song_waddr] <= song_wdata;
    end
  end

  assign entry       = song_q[idx_q];
  assign entry_raw   = entry[8:4];
  assign entry_beats = entry[3:0];
  assign entry_tone  = ((entry_raw != 5'd0) && (entry_raw <= 5'd21)) ? entry_raw : 5'd0;

  assign key_ok  = (key_code != 5'd0) && (key_code <= 5'd21);
  assign preempt = play_stop || key_ok;

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    idx_d   = idx_q;
    beats_d = beats_q;
    beat_d  = beat_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tone_d = key_ok ? key_code : 5'd0;
        if (play_start && !play_stop && !key_ok) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (preempt) begin
          state_d = ST_IDLE;
          tone_d  = 5'd0;
        end else if (entry_beats == 4'd0) begin
          tone_d = 5'd0;
          done_d = 1'b1;
`ifdef TONE_SCHED_LOOP_EN
          // An empty song at index 0 stops instead of spinning through LOAD forever.
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_NOTE;
          tone_d  = entry_tone;
          beats_d = entry_beats;
          beat_d  = 4'd0;
          tick_d  = '0;
        end
      end
      ST_NOTE: begin
        if (preempt) begin
          state_d = ST_IDLE;
          tone_d  = 5'd0;
        end else if (tick_q == BEAT_LAST) begin
          tick_d = '0;
          if (beat_q == beats_q - 4'd1) begin
            state_d = ST_GAP;
            tone_d  = 5'd0;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (preempt) begin
          state_d = ST_IDLE;
          tone_d  = 5'd0;
        end else if (tick_q == GAP_LAST) begin
          tick_d = '0;
          if (idx_q == LAST_IDX) begin
            done_d = 1'b1;
`ifdef TONE_SCHED_LOOP_EN
            state_d = ST_LOAD;
            idx_d   = '0;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + AW'(1);
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        tone_d  = 5'd0;
      end
      default: begin
        state_d = ST_IDLE;
        tone_d  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tone_q  <= 5'd0;
      idx_q   <= '0;
      beats_q <= 4'd0;
      beat_q  <= 4'd0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      idx_q   <= idx_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign tone      = tone_q;
  assign busy      = (state_q != ST_IDLE);
  assign note_idx  = idx_q;
  assign song_done = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed scenarios then random traffic, every cycle
// compared against an offset-within-entry playback model of the song rules.
module tb_tone_scheduler;

  localparam int BT    = 10;
  localparam int GT    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef TONE_SCHED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    key_code;
  logic          play_start;
  logic          play_stop;
  logic          song_we;
  logic [AW-1:0] song_waddr;
  logic [8:0]    song_wdata;
  logic [4:0]    tone;
  logic          busy;
  logic [AW-1:0] note_idx;
  logic          song_done;
  logic [2:0]    dbg_state;

  tone_scheduler #(
    .BEAT_TICKS (BT),
    .GAP_TICKS  (GT),
    .SONG_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .play_start (play_start),
    .play_stop  (play_stop),
    .song_we    (song_we),
    .song_waddr (song_waddr),
    .song_wdata (song_wdata),
    .tone       (tone),
    .busy       (busy),
    .note_idx   (note_idx),
    .song_done  (song_done),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: a playing song is (entry index, cycle offset within that entry's period).
  // Offset 0 is the load cycle, 1..beats*BT the note, then GT gap cycles.
  logic [8:0] m_tbl [DEPTH];
  bit         m_busy;
  bit         m_done_st;
  int         m_idx;
  int         m_off;
  int         m_beats;
  logic [4:0] m_note;
  logic [4:0] exp_tone;
  bit         exp_busy;
  bit         exp_done;

  int checks = 0;
  int errors = 0;
  int dut_done_cnt, model_done_cnt;
  int dut_max_idx, model_max_idx;

  function automatic logic [8:0] enc(input int t, input int b);
    enc = {5'(t), 4'(b)};
  endfunction

  task automatic model_reset();
    m_busy    = 1'b0;
    m_done_st = 1'b0;
    m_idx     = 0;
    m_off     = 0;
    exp_tone  = 5'd0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
  endtask

  task automatic end_of_song();
    exp_tone = 5'd0;
    exp_done = 1'b1;
    if (LOOP && m_idx != 0) begin
      m_idx = 0;
      m_off = 0;
    end else begin
      m_done_st = 1'b1;
    end
  endtask

  task automatic model_step();
    bit         key_ok;
    int         beats;
    logic [4:0] t;
    key_ok   = (key_code >= 5'd1) && (key_code <= 5'd21);
    exp_done = 1'b0;
    if (!m_busy) begin
      exp_tone = key_ok ? key_code : 5'd0;
      if (play_start && !play_stop && !key_ok) begin
        m_busy = 1'b1;
        m_idx  = 0;
        m_off  = 0;
        exp_tone = 5'd0;
      end
    end else if (m_done_st) begin
      m_busy    = 1'b0;
      m_done_st = 1'b0;
      exp_tone  = 5'd0;
    end else if (play_stop || key_ok) begin
      m_busy   = 1'b0;
      exp_tone = 5'd0;
    end else if (m_off == 0) begin
      beats = int'(m_tbl[m_idx][3:0]);
      if (beats == 0) begin
        end_of_song();
      end else begin
        t        = m_tbl[m_idx][8:4];
        m_beats  = beats;
        m_note   = (t >= 5'd1 && t <= 5'd21) ? t : 5'd0;
        m_off    = 1;
        exp_tone = m_note;
      end
    end else begin
      m_off = m_off + 1;
      if (m_off == 1 + m_beats * BT + GT) begin
        if (m_idx == DEPTH - 1) begin
          end_of_song();
        end else begin
          m_idx    = m_idx + 1;
          m_off    = 0;
          exp_tone = 5'd0;
        end
      end else if (m_off <= m_beats * BT) begin
        exp_tone = m_note;
      end else begin
        exp_tone = 5'd0;
      end
    end
    if (song_we) m_tbl[song_waddr] = song_wdata;
    exp_busy = m_busy;
    if (exp_done) model_done_cnt++;
    if (m_busy && m_idx > model_max_idx) model_max_idx = m_idx;
  endtask

  task automatic check_outputs();
    checks++;
    assert (tone === exp_tone) else begin
      errors++;
      $error("FAIL tone: got %0d expected %0d at %0t", tone, exp_tone, $time);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("FAIL busy: got %0b expected %0b at %0t", busy, exp_busy, $time);
    end
    checks++;
    assert (song_done === exp_done) else begin
      errors++;
      $error("FAIL song_done: got %0b expected %0b at %0t", song_done, exp_done, $time);
    end
    if (exp_busy) begin
      checks++;
      assert (note_idx === AW'(m_idx)) else begin
        errors++;
        $error("FAIL note_idx: got %0d expected %0d at %0t", note_idx, m_idx, $time);
      end
    end
  endtask

  // One clock: predict, advance, compare; strobes are single-cycle.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    if (song_done === 1'b1) dut_done_cnt++;
    if (busy === 1'b1 && int'(note_idx) > dut_max_idx) dut_max_idx = int'(note_idx);
    play_start = 1'b0;
    play_stop  = 1'b0;
    song_we    = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_entry(input int a, input logic [8:0] d);
    song_we    = 1'b1;
    song_waddr = AW'(a);
    song_wdata = d;
    step();
  endtask

  task automatic clear_stats();
    dut_done_cnt   = 0;
    model_done_cnt = 0;
    dut_max_idx    = 0;
    model_max_idx  = 0;
  endtask

  task automatic check_stats(input string tag);
    checks++;
    assert (dut_done_cnt === model_done_cnt) else begin
      errors++;
      $error("FAIL %s done_count: got %0d expected %0d", tag, dut_done_cnt, model_done_cnt);
    end
    checks++;
    assert (dut_max_idx === model_max_idx) else begin
      errors++;
      $error("FAIL %s max_idx: got %0d expected %0d", tag, dut_max_idx, model_max_idx);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    key_code   = 5'd0;
    play_start = 1'b0;
    play_stop  = 1'b0;
    song_we    = 1'b0;
    song_waddr = '0;
    song_wdata = '0;
    model_reset();
    clear_stats();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 9'd0;

    // Reset state
    #12;
    check_outputs();
    checks++;
    assert (note_idx === '0) else begin
      errors++;
      $error("FAIL reset_note_idx: got %0d expected 0", note_idx);
    end
    rst_n = 1'b1;

    // Live key: valid code after one cycle, out-of-range code is silence
    key_code = 5'd5;
    step();
    key_code = 5'd23;
    step();
    key_code = 5'd0;
    step();

    // Song with a rest and an end marker
    write_entry(0, enc(1, 1));
    write_entry(1, enc(8, 2));
    write_entry(2, enc(0, 1));
    write_entry(3, enc($urandom_range(0, 31), 0));
    clear_stats();
    play_start = 1'b1;
    run(60);
    play_stop = 1'b1;
    step();
    check_stats("song_rest");

    // Full table, finishing through the last gap
    write_entry(0, enc(2, 1));
    write_entry(1, enc(3, 1));
    write_entry(2, enc(25, 1));
    write_entry(3, enc(5, 2));
    clear_stats();
    play_start = 1'b1;
    run(70);
    play_stop = 1'b1;
    step();
    check_stats("song_full");

    // Key preempts mid-note, then sounds a cycle later
    play_start = 1'b1;
    run(4);
    key_code = 5'd12;
    run(2);
    key_code = 5'd0;
    step();

    // start+stop together; stop mid-gap
    play_start = 1'b1;
    play_stop  = 1'b1;
    step();
    play_start = 1'b1;
    run(12);
    play_stop = 1'b1;
    step();

    // Rewriting the playing entry leaves the current note intact
    play_start = 1'b1;
    run(3);
    write_entry(0, enc(9, 3));
    run(14);
    play_stop = 1'b1;
    step();

    // Asynchronous reset mid-note
    play_start = 1'b1;
    run(5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert (tone === 5'd0) else begin
      errors++;
      $error("FAIL async_reset_tone: got %0d expected 0", tone);
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("FAIL async_reset_busy: got %0b expected 0", busy);
    end
    model_reset();
    #2 rst_n = 1'b1;
    step();

`ifdef TONE_SCHED_LOOP_EN
    write_entry(0, enc(3, 1));
    write_entry(1, enc($urandom_range(0, 31), 0));
    clear_stats();
    play_start = 1'b1;
    run(45);
    play_stop = 1'b1;
    step();
    check_stats("loop_wrap");
    write_entry(0, enc($urandom_range(0, 31), 0));
    clear_stats();
    play_start = 1'b1;
    run(6);
    check_stats("loop_empty");
`endif

    // Random traffic: sparse keys, starts, stops and table writes
    clear_stats();
    for (int c = 0; c < 3000; c++) begin
      key_code   = ($urandom_range(0, 99) < 3) ? 5'($urandom_range(1, 31)) : 5'd0;
      play_start = ($urandom_range(0, 19) == 0);
      play_stop  = ($urandom_range(0, 149) == 0);
      song_we    = ($urandom_range(0, 29) == 0);
      song_waddr = AW'($urandom_range(0, DEPTH - 1));
      song_wdata = enc($urandom_range(0, 31), $urandom_range(0, 4));
      step();
    end
    check_stats("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
